led_arbiter: RTL and testbench
==============================

// Module: led_arbiter
// PURPOSE
//  Shares the board RGB LED (LED_RED/LED_BLUE/LED_GREEN) between N status requesters.
//  Fixed priority (index 0 highest), with a minimum display time so low-priority status is not flickered away.
//  Generates its own slow tick from SYSCLK and drives solid or blinking colours.
//  When no request is active, shows a green heartbeat. Sits between status sources and the LED pins.
// PARAMETERS
//  N            3          number of requesters (1..8)
//  CLKDIV       25000000   SYSCLK cycles per tick (>=2)
//  MIN_HOLD     4          ticks a granted colour is shown before it may be preempted or removed (>=1)
//  BLINK_TICKS  2          ticks per blink half-period (>=1)
// PORTS
//  SYSCLK     in   1    system clock, all logic on rising edge
//  RESET      in   1    asynchronous, active-high reset
//  REQ        in   N    request per requester, level, held while status valid
//  REQ_COLOR  in   3N   {G,B,R} per requester, requester i at [3i+2:3i]
//  REQ_BLINK  in   N    1 = blink requested colour, 0 = solid
//  GRANT      out  N    one-hot (or zero) current owner
//  LED_RED    out  1    registered LED drive
//  LED_BLUE   out  1    registered LED drive
//  LED_GREEN  out  1    registered LED drive
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, prescaler/hold/blink counters 0, phase 0, latched colour 0.
//  Prescaler: cnt 0..CLKDIV-1, wraps to 0; tick = 1-cycle pulse on the cycle cnt==CLKDIV-1.
//  Blink: counter advances on tick; phase toggles every BLINK_TICKS ticks, free-running in all states.
//  hold_cnt: cleared on every new grant; +1 per tick; saturates at MIN_HOLD; held = (hold_cnt==MIN_HOLD).
//  Winner = lowest index i with REQ[i]=1. All outputs registered: REQ at edge k -> GRANT/LEDs at edge k+1.
//  States:
//   IDLE:   GRANT=0; LEDs = {G=phase,B=0,R=0}. Any REQ -> SHOW, owner=winner, hold_cnt=0.
//   SHOW:   GRANT[owner]=1; colour/blink latched from REQ_COLOR/REQ_BLINK[owner] every cycle.
//           REQ[owner]=1 & winner<owner & held -> SHOW with owner=winner, hold_cnt=0 (no gap cycle).
//           REQ[owner]=1 & winner<owner & !held -> stay (preemption deferred until held).
//           REQ[owner]=0 & held & other REQ -> SHOW, owner=winner, hold_cnt=0.
//           REQ[owner]=0 & held & no REQ -> IDLE.
//           REQ[owner]=0 & !held -> LINGER.
//   LINGER: GRANT=0; LEDs show last latched colour/blink; hold_cnt keeps counting.
//           held & any REQ -> SHOW, owner=winner, hold_cnt=0.  held & no REQ -> IDLE.
//           Owner re-raising REQ in LINGER is treated as a new request only once held.
//  LED drive (SHOW/LINGER): colour if blink=0; colour & {3{phase}} if blink=1.
//  Simultaneous REQ: lowest index wins. Tick coinciding with grant: hold_cnt restarts at 0 (tick not counted).
//  Counters never exceed range; no wrap except prescaler and blink counter.
//  RESET asserted mid-operation: outputs 0 immediately (async); resumes in IDLE after deassert.
// TESTING (bench params: N=3, CLKDIV=4, MIN_HOLD=2, BLINK_TICKS=1)
//  1 Reset, no REQ -> GRANT=0, LED_GREEN toggles every 4 cycles, RED/BLUE=0.
//  2 REQ=3'b010, colour1=3'b001 solid -> next edge GRANT=3'b010, LED_RED=1, others 0.
//  3 REQ=3'b110 simultaneous -> GRANT=3'b010; drop REQ[1] -> GRANT=3'b100 one cycle later only after 2 ticks.
//  4 Owner 2 granted, REQ[0] rises after 1 tick -> GRANT stays 3'b100 until hold_cnt=2, then 3'b001 with no idle cycle.
//  5 Owner drops REQ 1 cycle after grant -> GRANT=0, colour held until 8 cycles elapsed, then heartbeat.
//  6 REQ_BLINK=1, colour 3'b111 -> all LEDs toggle every 4 cycles in phase; RESET mid-blink -> all outputs 0 same cycle.

Source files
------------

// File: rtl/led_arbiter.sv
// Fixed-priority arbiter sharing one RGB LED between N status sources.
// Granted colours are held for a minimum number of slow ticks. With no requests the LED shows a green heartbeat.
module led_arbiter #(
  parameter int N           = 3,
  parameter int CLKDIV      = 25000000,
  parameter int MIN_HOLD    = 4,
  parameter int BLINK_TICKS = 2
) (
  input  logic           SYSCLK,
  input  logic           RESET,
  input  logic [N-1:0]   REQ,
  input  logic [3*N-1:0] REQ_COLOR,
  input  logic [N-1:0]   REQ_BLINK,
  output logic [N-1:0]   GRANT,
  output logic           LED_RED,
  output logic           LED_BLUE,
  output logic           LED_GREEN
);

  localparam int CW = $clog2(CLKDIV);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKDIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          phase_q, phase_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [2:0]    color_q, color_d;
  logic          blink_q, blink_d;
  logic [N-1:0]  grant_d;
  logic [2:0]    led_d;
  logic          tick, held, anyReq, grantNew;
  logic [OW-1:0] winner;

  assign tick = (cnt_q == CNT_MAX);
  assign held = (holdCnt_q == HOLD_MAX);

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    blinkCnt_d = blinkCnt_q;
    phase_d    = phase_q;
    if (tick) begin
      if (blinkCnt_q == BLINK_MAX) begin
        blinkCnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  // Scanning downward leaves the lowest requesting index as the winner.
  always_comb begin
    anyReq = |REQ;
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (REQ[i]) winner = OW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grantNew = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d  = SHOW;
          owner_d  = winner;
          grantNew = 1'b1;
        end
      end
      SHOW: begin
        if (REQ[owner_q]) begin
          if ((winner < owner_q) && held) begin
            owner_d  = winner;
            grantNew = 1'b1;
          end
        end else if (held) begin
          if (anyReq) begin
            owner_d  = winner;
            grantNew = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = LINGER;
        end
      end
      LINGER: begin
        if (held) begin
          if (anyReq) begin
            state_d  = SHOW;
            owner_d  = winner;
            grantNew = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick landing on the grant cycle is deliberately not counted.
    holdCnt_d = holdCnt_q;
    if (grantNew) holdCnt_d = '0;
    else if (tick && !held) holdCnt_d = holdCnt_q + 1'b1;

    color_d = color_q;
    blink_d = blink_q;
    grant_d = '0;
    for (int i = 0; i < N; i++) begin
      if ((state_d == SHOW) && (owner_d == OW'(i))) begin
        color_d    = REQ_COLOR[3*i +: 3];
        blink_d    = REQ_BLINK[i];
        grant_d[i] = 1'b1;
      end
    end

    if (state_d == IDLE) led_d = {phase_d, 2'b00};
    else if (blink_d)    led_d = color_d & {3{phase_d}};
    else                 led_d = color_d;
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      blinkCnt_q <= '0;
      phase_q    <= 1'b0;
      holdCnt_q  <= '0;
      owner_q    <= '0;
      color_q    <= '0;
      blink_q    <= 1'b0;
      GRANT      <= '0;
      LED_GREEN  <= 1'b0;
      LED_BLUE   <= 1'b0;
      LED_RED    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
      holdCnt_q  <= holdCnt_d;
      owner_q    <= owner_d;
      color_q    <= color_d;
      blink_q    <= blink_d;
      GRANT      <= grant_d;
      {LED_GREEN, LED_BLUE, LED_RED} <= led_d;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Randomized bench for led_arbiter. An edge-counting reference model predicts GRANT and LED values on every cycle.
module tb_led_arbiter;
  localparam int N = 3, CLKDIV = 4, MIN_HOLD = 2, BLINK_TICKS = 1;

  logic           SYSCLK = 1'b0;
  logic           RESET = 1'b1;
  logic [N-1:0]   REQ = '0;
  logic [3*N-1:0] REQ_COLOR = '0;
  logic [N-1:0]   REQ_BLINK = '0;
  logic [N-1:0]   GRANT;
  logic           LED_RED, LED_BLUE, LED_GREEN;

  int checks = 0;
  int failures = 0;

  int edgeCount, mMode, mOwner, mTicks;
  logic [2:0] mColor;
  logic mBlink;

  led_arbiter #(.N(N), .CLKDIV(CLKDIV), .MIN_HOLD(MIN_HOLD), .BLINK_TICKS(BLINK_TICKS)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .REQ(REQ), .REQ_COLOR(REQ_COLOR), .REQ_BLINK(REQ_BLINK),
    .GRANT(GRANT), .LED_RED(LED_RED), .LED_BLUE(LED_BLUE), .LED_GREEN(LED_GREEN)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    edgeCount = 0; mMode = 0; mOwner = 0; mTicks = 0; mColor = '0; mBlink = 1'b0;
  endtask

  // Mode 0 idle, 1 showing, 2 lingering. mTicks counts whole ticks since the last grant.
  task automatic modelEdge();
    int winner = -1;
    bit held, grant, tickNow;
    grant = 0;
    for (int i = N - 1; i >= 0; i--) if (REQ[i]) winner = i;
    held = (mTicks >= MIN_HOLD);
    edgeCount++;
    tickNow = (edgeCount % CLKDIV) == 0;
    case (mMode)
      0: if (winner >= 0) grant = 1;
      1: begin
        if (REQ[mOwner]) begin
          if (winner < mOwner && held) grant = 1;
        end else if (held) begin
          if (winner >= 0) grant = 1; else mMode = 0;
        end else mMode = 2;
      end
      default: if (held) begin
        if (winner >= 0) grant = 1; else mMode = 0;
      end
    endcase
    if (grant) begin
      mMode = 1; mOwner = winner; mTicks = 0;
    end else if (tickNow) mTicks++;
    if (mMode == 1) begin
      mColor = REQ_COLOR[3*mOwner +: 3];
      mBlink = REQ_BLINK[mOwner];
    end
  endtask

  function automatic logic [2:0] expLeds();
    logic phase;
    phase = ((edgeCount / CLKDIV) / BLINK_TICKS) % 2;
    if (mMode == 0) return {phase, 2'b00};
    return mBlink ? (mColor & {3{phase}}) : mColor;
  endfunction

  function automatic logic [N-1:0] expGrant();
    return (mMode == 1) ? N'(1 << mOwner) : '0;
  endfunction

  task automatic step();
    @(posedge SYSCLK);
    modelEdge();
    #1;
    checkOutput("grant", GRANT, expGrant());
    checkOutput("leds", {LED_GREEN, LED_BLUE, LED_RED}, expLeds());
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [3*N-1:0] colors, input logic [N-1:0] blink);
    REQ = req; REQ_COLOR = colors; REQ_BLINK = blink;
  endtask

  task automatic doReset();
    RESET = 1'b1;
    #1;
    checkOutput("reset_async_grant", GRANT, 0);
    checkOutput("reset_async_leds", {LED_GREEN, LED_BLUE, LED_RED}, 0);
    repeat (2) @(posedge SYSCLK);
    #1;
    RESET = 1'b0;
    modelReset();
    checkOutput("reset_state", {GRANT, LED_GREEN, LED_BLUE, LED_RED}, 0);
  endtask

  initial begin
    #2;
    doReset();
    repeat (9) step();

    applyStimulus(3'b010, {3'b000, 3'b001, 3'b000}, 3'b000);
    step();
    checkOutput("t2_grant", GRANT, 3'b010);
    checkOutput("t2_leds", {LED_GREEN, LED_BLUE, LED_RED}, 3'b001);

    doReset();
    applyStimulus(3'b110, {3'b100, 3'b010, 3'b001}, 3'b000);
    repeat (3) step();
    applyStimulus(3'b100, {3'b100, 3'b010, 3'b001}, 3'b000);
    repeat (12) step();

    doReset();
    applyStimulus(3'b100, {3'b100, 3'b010, 3'b001}, 3'b000);
    repeat (5) step();
    applyStimulus(3'b101, {3'b100, 3'b010, 3'b001}, 3'b000);
    repeat (10) step();

    doReset();
    applyStimulus(3'b010, {3'b000, 3'b110, 3'b000}, 3'b000);
    step();
    applyStimulus(3'b000, {3'b000, 3'b110, 3'b000}, 3'b000);
    repeat (14) step();

    doReset();
    applyStimulus(3'b001, {3'b000, 3'b000, 3'b111}, 3'b001);
    repeat (13) step();
    doReset();
    repeat (3) step();

    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      if ($urandom_range(0, 5) == 0) REQ = N'($urandom);
      if ($urandom_range(0, 9) == 0) REQ_COLOR = (3*N)'($urandom);
      if ($urandom_range(0, 9) == 0) REQ_BLINK = N'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
